// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD path: ILI9341 opcodes, pattern sequencer states
// and the colour-bar palette.
package lcd_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CASET_C,
        ST_CASET_D,
        ST_PASET_C,
        ST_PASET_D,
        ST_RAMWR_C,
        ST_PIX_HI,
        ST_PIX_LO,
        ST_DONE
    } state_t;

    localparam logic [15:0] BAR_COLOURS [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

    // Window argument bytes: start address is always 0, then the end address MSB first.
    function automatic logic [7:0] window_byte(input logic [15:0] last, input logic [1:0] idx);
        case (idx)
            2'd2:    return last[15:8];
            2'd3:    return last[7:0];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/lcd_pattern_pix.sv
// Pixel raster walker: in-bar x, bar and line counters plus colour selection.
module lcd_pattern_pix
    import lcd_pkg::*;
#(
    parameter int V_RES = 240,
    parameter int BAR_W = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    input  logic        clr,
    input  logic [2:0]  ofs,
    input  logic        mode,
    input  logic [15:0] colour,
    output logic [15:0] pixel,
    output logic        last
);

    localparam int XW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [XW-1:0] X_END = XW'(BAR_W - 1);
    localparam logic [YW-1:0] Y_END = YW'(V_RES - 1);

    logic [XW-1:0] x_cnt;
    logic [2:0]    bar_cnt;
    logic [YW-1:0] y_cnt;
    logic [2:0]    bar;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_cnt   <= '0;
            bar_cnt <= '0;
            y_cnt   <= '0;
        end else if (clr) begin
            x_cnt   <= '0;
            bar_cnt <= '0;
            y_cnt   <= '0;
        end else if (adv) begin
            if (x_cnt == X_END) begin
                x_cnt   <= '0;
                bar_cnt <= bar_cnt + 3'd1;
                if (bar_cnt == 3'd7) begin
                    y_cnt <= (y_cnt == Y_END) ? '0 : y_cnt + YW'(1);
                end
            end else begin
                x_cnt <= x_cnt + XW'(1);
            end
        end
    end

    // Eight bars span exactly one line, so the 3-bit sum wraps as the mod-8 rotation.
    assign bar   = bar_cnt + ofs;
    assign pixel = mode ? colour : BAR_COLOURS[bar];
    assign last  = (bar_cnt == 3'd7) && (x_cnt == X_END) && (y_cnt == Y_END);

endmodule

// File: rtl/lcd_pattern_gen.sv
// Self-test frame source: on frame mark, streams the ILI9341 window setup, RAMWR
// and a full RGB565 frame onto the PHY byte interface.
module lcd_pattern_gen
    import lcd_pkg::*;
#(
    parameter int H_RES = 320,
    parameter int V_RES = 240,
    parameter int BAR_W = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        mode,
    input  logic        scroll,
    input  logic [15:0] colour,
    output logic [7:0]  phy_data,
    output logic        phy_rs,
    output logic        phy_valid,
    input  logic        phy_ready,
    input  logic        phy_fmark_stb,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [15:0] H_END = 16'(H_RES - 1);
    localparam logic [15:0] V_END = 16'(V_RES - 1);

    state_t      state, state_n;
    logic [1:0]  idx, idx_n;
    logic [2:0]  frame_cnt;
    logic        mode_q, scroll_q, last_q;
    logic [15:0] colour_q;
    logic        valid_n, rs_n, start, adv, xfer;
    logic [7:0]  data_n;
    logic [2:0]  ofs;
    logic [15:0] pixel;
    logic        pix_last;

    assign xfer = phy_valid & phy_ready;
    assign ofs  = scroll_q ? frame_cnt : '0;

    lcd_pattern_pix #(
        .V_RES (V_RES),
        .BAR_W (BAR_W)
    ) u_pix (
        .clk    (clk),
        .rst    (rst),
        .adv    (adv),
        .clr    (start),
        .ofs    (ofs),
        .mode   (mode_q),
        .colour (colour_q),
        .pixel  (pixel),
        .last   (pix_last)
    );

    // State describes the byte sitting in the output register; each transfer loads
    // the following byte in the same cycle so the stream has no bubbles.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        valid_n = phy_valid;
        data_n  = phy_data;
        rs_n    = phy_rs;
        start   = 1'b0;
        adv     = 1'b0;
        unique case (state)
            ST_IDLE: if (phy_fmark_stb && enable) begin
                state_n = ST_CASET_C;
                valid_n = 1'b1;
                data_n  = CMD_CASET;
                rs_n    = 1'b0;
                start   = 1'b1;
            end
            ST_CASET_C: if (xfer) begin
                state_n = ST_CASET_D;
                idx_n   = '0;
                data_n  = window_byte(H_END, 2'd0);
                rs_n    = 1'b1;
            end
            ST_CASET_D: if (xfer) begin
                if (idx == 2'd3) begin
                    state_n = ST_PASET_C;
                    data_n  = CMD_PASET;
                    rs_n    = 1'b0;
                end else begin
                    idx_n  = idx + 2'd1;
                    data_n = window_byte(H_END, idx + 2'd1);
                end
            end
            ST_PASET_C: if (xfer) begin
                state_n = ST_PASET_D;
                idx_n   = '0;
                data_n  = window_byte(V_END, 2'd0);
                rs_n    = 1'b1;
            end
            ST_PASET_D: if (xfer) begin
                if (idx == 2'd3) begin
                    state_n = ST_RAMWR_C;
                    data_n  = CMD_RAMWR;
                    rs_n    = 1'b0;
                end else begin
                    idx_n  = idx + 2'd1;
                    data_n = window_byte(V_END, idx + 2'd1);
                end
            end
            ST_RAMWR_C: if (xfer) begin
                state_n = ST_PIX_HI;
                data_n  = pixel[15:8];
                rs_n    = 1'b1;
            end
            // The raster advances as the low byte is loaded; last_q remembers
            // whether the pixel now on the bus was the final one.
            ST_PIX_HI: if (xfer) begin
                state_n = ST_PIX_LO;
                data_n  = pixel[7:0];
                adv     = 1'b1;
            end
            ST_PIX_LO: if (xfer) begin
                if (last_q) begin
                    state_n = ST_DONE;
                    valid_n = 1'b0;
                    data_n  = '0;
                    rs_n    = 1'b0;
                end else begin
                    state_n = ST_PIX_HI;
                    data_n  = pixel[15:8];
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: begin
                state_n = ST_IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            frame_cnt  <= '0;
            mode_q     <= 1'b0;
            scroll_q   <= 1'b0;
            colour_q   <= '0;
            last_q     <= 1'b0;
            phy_valid  <= 1'b0;
            phy_data   <= '0;
            phy_rs     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            phy_valid  <= valid_n;
            phy_data   <= data_n;
            phy_rs     <= rs_n;
            busy       <= (state_n != ST_IDLE);
            frame_done <= (state_n == ST_DONE);
            if (start) begin
                mode_q   <= mode;
                scroll_q <= scroll;
                colour_q <= colour;
                last_q   <= 1'b0;
            end else if (adv) begin
                last_q <= pix_last;
            end
            if (state == ST_DONE) begin
                frame_cnt <= frame_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Self-checking bench for lcd_pattern_gen on a reduced 16x3 raster with 2-pixel bars.
module tb_lcd_pattern_gen;

    localparam int H     = 16;
    localparam int V     = 3;
    localparam int BW    = 2;
    localparam int TOTAL = 11 + 2 * H * V;

    logic        clk = 1'b0;
    logic        rst, enable, mode, scroll, phy_ready, phy_fmark_stb;
    logic [15:0] colour;
    logic [7:0]  phy_data;
    logic        phy_rs, phy_valid, busy, frame_done;

    int checks = 0;
    int failures = 0;
    bit stall_mode = 1'b0;

    logic [7:0] cap_d [128];
    logic       cap_rs [128];
    logic [7:0] ref_d [128];
    logic       ref_rs [128];

    bit          m_active, m_done_next, m_mode, m_scroll, prev_stall;
    logic [15:0] m_colour;
    int          m_idx, m_frames;
    logic [7:0]  prev_d;
    logic        prev_rs;

    always #5 clk = ~clk;

    lcd_pattern_gen #(.H_RES(H), .V_RES(V), .BAR_W(BW)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .mode          (mode),
        .scroll        (scroll),
        .colour        (colour),
        .phy_data      (phy_data),
        .phy_rs        (phy_rs),
        .phy_valid     (phy_valid),
        .phy_ready     (phy_ready),
        .phy_fmark_stb (phy_fmark_stb),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] palette(input int i);
        case (i)
            0: return 16'hFFFF;  1: return 16'hFFE0;
            2: return 16'h07FF;  3: return 16'h07E0;
            4: return 16'hF81F;  5: return 16'hF800;
            6: return 16'h001F;  default: return 16'h0000;
        endcase
    endfunction

    // Expected {rs,data} of byte k of a frame, straight from the raster/bar rules.
    function automatic logic [8:0] exp_byte(input int k, input bit md, input bit sc,
                                            input logic [15:0] col, input int frames);
        int p, x, bar;
        logic [15:0] c;
        if (k < 11) begin
            case (k)
                0:       return {1'b0, 8'h2A};
                3:       return {1'b1, 8'((H - 1) / 256)};
                4:       return {1'b1, 8'((H - 1) % 256)};
                5:       return {1'b0, 8'h2B};
                8:       return {1'b1, 8'((V - 1) / 256)};
                9:       return {1'b1, 8'((V - 1) % 256)};
                10:      return {1'b0, 8'h2C};
                default: return {1'b1, 8'h00};
            endcase
        end
        if (k >= TOTAL) return 9'h1FF;
        p   = (k - 11) / 2;
        x   = p % H;
        bar = (x / BW + (sc ? frames % 8 : 0)) % 8;
        c   = md ? col : palette(bar);
        return {1'b1, ((k - 11) % 2 == 0) ? c[15:8] : c[7:0]};
    endfunction

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_valid", 32'(phy_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(frame_done), 0);
            chk("rst_data", 32'(phy_data), 0);
            chk("rst_rs", 32'(phy_rs), 0);
            m_active = 0; m_done_next = 0; m_idx = 0; m_frames = 0; prev_stall = 0;
        end else begin
            bit xf;
            xf = 0;
            chk("busy", 32'(busy), 32'(m_active));
            chk("frame_done", 32'(frame_done), 32'(m_done_next));
            if (m_done_next) chk("valid_in_done", 32'(phy_valid), 0);
            if (!m_active) chk("valid_idle", 32'(phy_valid), 0);
            if (prev_stall) begin
                chk("hold_valid", 32'(phy_valid), 1);
                chk("hold_data", 32'(phy_data), 32'(prev_d));
                chk("hold_rs", 32'(phy_rs), 32'(prev_rs));
            end
            if (phy_valid && phy_ready && m_active && !m_done_next) begin
                chk($sformatf("byte%0d", m_idx), 32'({phy_rs, phy_data}),
                    32'(exp_byte(m_idx, m_mode, m_scroll, m_colour, m_frames)));
                if (m_idx < 128) begin
                    cap_d[m_idx]  = phy_data;
                    cap_rs[m_idx] = phy_rs;
                end
                m_idx++;
                xf = 1;
            end
            prev_stall = phy_valid && !phy_ready;
            prev_d     = phy_data;
            prev_rs    = phy_rs;
            if (m_done_next) begin
                m_active    = 0;
                m_done_next = 0;
                m_frames    = (m_frames + 1) % 8;
            end else if (!m_active) begin
                if (phy_fmark_stb && enable) begin
                    m_active = 1; m_idx = 0;
                    m_mode = mode; m_scroll = scroll; m_colour = colour;
                end
            end else if (xf && m_idx == TOTAL) begin
                m_done_next = 1;
            end
        end
    end

    initial begin
        phy_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            phy_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic strobe();
        @(posedge clk); #1 phy_fmark_stb = 1'b1;
        @(posedge clk); #1 phy_fmark_stb = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_done) begin ok = 1; break; end
        end
        chk("done_timeout", 32'(ok), 1);
        @(posedge clk); #1;
    endtask

    task automatic chk_pix(input string name, input int p, input logic [15:0] req);
        chk(name, 32'({cap_d[11 + 2 * p], cap_d[12 + 2 * p]}), 32'(req));
    endtask

    initial begin
        logic [7:0] hdr [11];
        logic       hrs [11];
        int         nmis;
        hdr = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h2B, 8'h00, 8'h00, 8'h00, 8'h02, 8'h2C};
        hrs = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        rst = 1'b0; enable = 1'b0; mode = 1'b0; scroll = 1'b0;
        colour = '0; phy_fmark_stb = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Colour bars, no stalls; first byte latency and header/pixel literals.
        enable = 1'b1;
        @(posedge clk); #1 phy_fmark_stb = 1'b1;
        @(posedge clk); #1 phy_fmark_stb = 1'b0;
        @(negedge clk);
        chk("lat_valid", 32'(phy_valid), 1);
        chk("lat_data", 32'(phy_data), 32'h2A);
        wait_done(400);
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("hdr%0d", i), 32'({cap_rs[i], cap_d[i]}), 32'({hrs[i], hdr[i]}));
        end
        chk_pix("pix0", 0, 16'hFFFF);
        chk_pix("pix2", 2, 16'hFFE0);
        chk_pix("pix15", 15, 16'h0000);
        chk("frame_bytes", 32'(m_idx), 107);
        for (int i = 0; i < TOTAL; i++) begin ref_d[i] = cap_d[i]; ref_rs[i] = cap_rs[i]; end

        // Same frame under random back-pressure.
        stall_mode = 1'b1;
        strobe();
        wait_done(2000);
        stall_mode = 1'b0;
        nmis = 0;
        for (int i = 0; i < TOTAL; i++) begin
            if (cap_d[i] !== ref_d[i] || cap_rs[i] !== ref_rs[i]) nmis++;
        end
        chk("stall_same_seq", 32'(nmis), 0);

        // Solid colour; changing colour mid-frame must not leak in.
        mode = 1'b1; colour = 16'h1234;
        strobe();
        repeat (20) @(posedge clk);
        #1 colour = 16'hABCD;
        wait_done(400);
        chk_pix("solid_first", 0, 16'h1234);
        chk_pix("solid_last", H * V - 1, 16'h1234);
        mode = 1'b0;

        // Scroll across three frames from reset.
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk); #1 rst = 1'b1;
        scroll = 1'b1;
        strobe(); wait_done(400); chk_pix("scroll_f0", 0, 16'hFFFF);
        strobe(); wait_done(400); chk_pix("scroll_f1", 0, 16'hFFE0);
        strobe(); wait_done(400); chk_pix("scroll_f2", 0, 16'h07FF);
        scroll = 1'b0;

        // Extra frame mark mid-frame and enable dropped: frame completes, no restart.
        strobe();
        repeat (20) @(posedge clk);
        #1 phy_fmark_stb = 1'b1;
        @(posedge clk); #1 phy_fmark_stb = 1'b0; enable = 1'b0;
        wait_done(400);
        chk("drop_frame_bytes", 32'(cap_d[0]), 32'h2A);
        strobe();
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("disabled_valid", 32'(phy_valid), 0);
        chk("disabled_busy", 32'(busy), 0);

        // Asynchronous reset mid-pixel.
        enable = 1'b1;
        strobe();
        repeat (30) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("async_rst_valid", 32'(phy_valid), 0);
        chk("async_rst_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        strobe();
        wait_done(400);
        chk("post_rst_first", 32'(cap_d[0]), 32'h2A);
        chk_pix("post_rst_pix0", 0, 16'hFFFF);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
